// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage sequencer (master) and the data memory (slave).
// req/gnt accept the address phase; rvalid/rdata return the response for loads and stores.
interface mem_access_ctrl_if #(
    parameter int unsigned REG_WIDTH = 32
) ();
    logic                 dmem_req;
    logic                 dmem_we;
    logic [REG_WIDTH-1:0] dmem_addr;
    logic [REG_WIDTH-1:0] dmem_wdata;
    logic                 dmem_gnt;
    logic                 dmem_rvalid;
    logic [REG_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: runs one req/gnt/rvalid word access per load/store in
// EX/MEM, stalls the upstream pipeline until it completes, and flags misalign/timeout.
module mem_access_ctrl #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           EX_MEM_inst_opcode,
    input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
    input  logic                 mem_flush,
    mem_access_ctrl_if.master    dmem,
    output logic                 mem_stall,
    output logic [REG_WIDTH-1:0] load_data,
    output logic                 load_valid,
    output logic                 misalign_err,
    output logic                 bus_err
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 req_q;
    logic                 we_q;
    logic [REG_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0] wdata_q;
    logic [REG_WIDTH-1:0] load_data_q;
    logic                 load_valid_q;
    logic                 misalign_q;
    logic                 bus_err_q;

    logic is_load;
    logic is_store;
    logic is_mem;
    logic timeout;

    assign is_load  = (EX_MEM_inst_opcode == OpLoad);
    assign is_store = (EX_MEM_inst_opcode == OpStore);
    assign is_mem   = is_load | is_store;
    // >= rather than == so a gnt won on the last cycle still leaves RSP bounded.
    assign timeout  = (cnt_q >= CntLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (is_mem && !mem_flush) begin
                        if (EX_MEM_alu_out[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
                            wdata_q <= EX_MEM_dataB;
                            cnt_q   <= '0;
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem.dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= StRsp;
                    end else if (timeout) begin
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StRsp: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem.dmem_rvalid) begin
                        if (!we_q) begin
                            load_data_q  <= dmem.dmem_rdata;
                            load_valid_q <= 1'b1;
                        end
                        state_q <= StDone;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // IDLE stall is combinational so EX/MEM freezes in the same cycle the op is decoded.
    always_comb begin
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle:       mem_stall = is_mem & ~mem_flush & ~reset;
            StReq, StRsp: mem_stall = 1'b1;
            StDone:       mem_stall = 1'b0;
            default:      mem_stall = 1'b0;
        endcase
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: stimulus predicts each access outcome,
// a bus responder plays back chosen gnt/rvalid delays, and a monitor checks what appears.
module tb_mem_access_ctrl;
    localparam int unsigned W  = 32;
    localparam int          TO = 16;
    localparam int          NEVER = 99;
    localparam logic [6:0]  LOAD  = 7'b0000011;
    localparam logic [6:0]  STORE = 7'b0100011;

    typedef struct {int gd; int rd; logic [W-1:0] rdata;} resp_t;
    typedef struct {logic [W-1:0] addr; logic we; logic [W-1:0] wdata;} txn_t;
    typedef struct {logic [2:0] kind; logic [W-1:0] data;} res_t;  // kind = {lv, mis, be}

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   opcode;
    logic [W-1:0] alu_out;
    logic [W-1:0] data_b;
    logic         mem_flush;
    logic         mem_stall;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         misalign_err;
    logic         bus_err;

    mem_access_ctrl_if #(.REG_WIDTH(W)) dmem ();

    mem_access_ctrl #(
        .REG_WIDTH      (W),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .EX_MEM_inst_opcode (opcode),
        .EX_MEM_alu_out     (alu_out),
        .EX_MEM_dataB       (data_b),
        .mem_flush          (mem_flush),
        .dmem               (dmem),
        .mem_stall          (mem_stall),
        .load_data          (load_data),
        .load_valid         (load_valid),
        .misalign_err       (misalign_err),
        .bus_err            (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    resp_t resp_q[$];
    txn_t  txn_q[$];
    res_t  res_q[$];
    int    stall_q[$];
    logic  mon_en = 1'b0;
    logic [W-1:0] last_ld = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
    endtask

    // Memory responder: grants after gd REQ cycles, answers rd RSP cycles later.
    int    ph = 0;
    int    k  = 0;
    resp_t cur;
    always @(negedge clk) begin
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = $urandom;
        if (reset) begin
            ph = 0;
        end else begin
            if (ph == 0 && dmem.dmem_req) begin
                if (resp_q.size() == 0) begin
                    fail_now("unexpected_request");
                    cur = '{NEVER, NEVER, '0};
                end else begin
                    cur = resp_q.pop_front();
                end
                k  = 0;
                ph = 1;
            end
            if (ph == 1) begin
                if (!dmem.dmem_req) begin
                    ph = 0;
                end else begin
                    dmem.dmem_rvalid = 1'($urandom % 2);  // noise: must be ignored in REQ
                    if (k == cur.gd) begin
                        dmem.dmem_gnt = 1'b1;
                        ph = 2;
                        k  = 0;
                    end else begin
                        k++;
                    end
                end
            end else if (ph == 2) begin
                if (!mem_stall) begin
                    ph = 0;
                end else if (k == cur.rd) begin
                    dmem.dmem_rvalid = 1'b1;
                    dmem.dmem_rdata  = cur.rdata;
                    ph = 0;
                end else begin
                    k++;
                end
            end
        end
    end

    // Monitor: compares stall runs, bus address phase, pulses and load_data to the queues.
    int   run = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        txn_t t;
        res_t r;
        logic [2:0] kind;
        #2;
        if (!mon_en) begin
            run = 0;
            req_prev = 1'b0;
        end else begin
            if (mem_stall) begin
                run++;
            end else if (run > 0) begin
                if (stall_q.size() == 0) fail_now("stall_run");
                else chk("stall_len", 64'(run), 64'(stall_q.pop_front()));
                run = 0;
            end
            if (dmem.dmem_req) begin
                if (txn_q.size() == 0) begin
                    fail_now("req_no_txn");
                end else begin
                    t = txn_q[0];
                    chk("req_addr", dmem.dmem_addr, t.addr);
                    chk("req_we", dmem.dmem_we, t.we);
                    if (t.we) chk("req_wdata", dmem.dmem_wdata, t.wdata);
                end
            end
            if (req_prev && !dmem.dmem_req && txn_q.size() > 0) void'(txn_q.pop_front());
            req_prev = dmem.dmem_req;
            kind = {load_valid, misalign_err, bus_err};
            if (kind != 3'b000) begin
                if (res_q.size() == 0) begin
                    fail_now("pulse_unexpected");
                end else begin
                    r = res_q.pop_front();
                    chk("pulse_kind", kind, r.kind);
                    if (r.kind == 3'b100) last_ld = r.data;
                end
            end
            chk("load_data", load_data, last_ld);
        end
    end

    // Drive one EX/MEM instruction (called at a negedge), predict its outcome, hold it
    // until the stall releases, and return at the negedge where the next one may enter.
    task automatic issue(input int kind, input logic [W-1:0] addr, input logic [W-1:0] data,
                         input int gd, input int rd, input logic [W-1:0] rdata,
                         input logic flush);
        logic [6:0] op;
        int bound;
        if (kind == 0) begin
            do op = 7'($urandom); while (op == LOAD || op == STORE);
        end else begin
            op = (kind == 1) ? LOAD : STORE;
        end
        opcode = op;
        alu_out = addr;
        data_b = data;
        mem_flush = flush;
        if (kind != 0 && !flush) begin
            if (addr[1:0] != 2'b00) begin
                res_q.push_back('{3'b010, '0});
                stall_q.push_back(1);
            end else begin
                txn_q.push_back('{addr, kind == 2, data});
                resp_q.push_back('{gd, rd, rdata});
                if (gd < TO && gd + 1 + rd < TO) begin
                    if (kind == 1) res_q.push_back('{3'b100, rdata});
                    stall_q.push_back(gd + rd + 3);
                end else begin
                    res_q.push_back('{3'b001, '0});
                    stall_q.push_back(TO + 1);
                end
            end
        end
        #1;
        bound = 0;
        while (mem_stall && bound < 100) begin
            @(negedge clk);
            mem_flush = 1'($urandom % 2);  // flush must be ignored once the access started
            #1;
            bound++;
        end
        if (bound >= 100) fail_now("stall_timeout");
        @(negedge clk);
    endtask

    task automatic reset_mid(input int cycles_in);
        resp_q.push_back('{(cycles_in == 1) ? NEVER : 0, NEVER, '0});
        opcode = LOAD;
        alu_out = 32'h40;
        mem_flush = 1'b0;
        repeat (cycles_in) @(negedge clk);
        #3;
        chk("pre_reset_stall", mem_stall, 1'b1);
        chk("pre_reset_req", dmem.dmem_req, (cycles_in == 1) ? 1'b1 : 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_req", dmem.dmem_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_pulses", {load_valid, misalign_err, bus_err}, 3'b000);
        chk("rst_load_data", load_data, '0);
        opcode = 7'b0110011;
        @(negedge clk);
        reset = 1'b0;
        last_ld = '0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst_quiet", {dmem.dmem_req, mem_stall, load_valid, misalign_err, bus_err},
                5'b00000);
        end
    endtask

    initial begin
        int m;
        int kd;
        int gd;
        int rd;
        logic [W-1:0] a;
        reset = 1'b1;
        opcode = LOAD;
        alu_out = 32'h100;
        data_b = '0;
        mem_flush = 1'b0;
        #13;
        chk("reset_outputs", {mem_stall, dmem.dmem_req, dmem.dmem_we, load_valid,
            misalign_err, bus_err}, 6'b0);
        chk("reset_addr", dmem.dmem_addr, '0);
        chk("reset_wdata", dmem.dmem_wdata, '0);
        chk("reset_load_data", load_data, '0);
        opcode = 7'b0010011;
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        issue(1, 32'h100, '0, 0, 0, 32'hDEADBEEF, 1'b0);
        issue(2, 32'h204, 32'h12345678, 4, 0, '0, 1'b0);
        issue(1, 32'h102, '0, 0, 0, '0, 1'b0);
        issue(1, 32'h300, '0, 0, NEVER, '0, 1'b0);
        issue(1, 32'h310, '0, NEVER, 0, '0, 1'b0);
        issue(1, 32'h104, '0, 0, 0, 32'h0BADF00D, 1'b1);
        issue(2, 32'h400, 32'hA5A5A5A5, 0, 0, '0, 1'b0);
        issue(2, 32'h404, 32'h5A5A5A5A, 2, 1, '0, 1'b0);
        issue(1, 32'h500, '0, 5, 9, 32'h11112222, 1'b0);
        issue(1, 32'h504, '0, 5, 10, 32'h33334444, 1'b0);
        issue(0, 32'h0, '0, 0, 0, '0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            kd = $urandom_range(0, 9);
            kd = (kd < 2) ? 0 : (kd < 6) ? 1 : 2;
            a = $urandom & ~32'h3;
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            m = $urandom_range(0, 9);
            if (m == 0) begin
                gd = NEVER; rd = 0;
            end else if (m == 1) begin
                gd = $urandom_range(0, 4); rd = NEVER;
            end else if (m == 2) begin
                gd = $urandom_range(0, 13); rd = 14 - gd + $urandom_range(0, 1);
            end else begin
                gd = $urandom_range(0, 6); rd = $urandom_range(0, 6);
            end
            issue(kd, a, $urandom, gd, rd, $urandom, ($urandom_range(0, 9) == 0));
        end

        issue(0, 32'h0, '0, 0, 0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("queues_drained", 64'(res_q.size() + txn_q.size() + stall_q.size() + resp_q.size()),
            64'd0);

        mon_en = 1'b0;
        reset_mid(2);
        reset_mid(1);
        resp_q.delete();
        txn_q.delete();
        res_q.delete();
        stall_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        issue(1, 32'h600, '0, 1, 1, 32'hCAFEF00D, 1'b0);
        issue(2, 32'h604, 32'h87654321, 0, 0, '0, 1'b0);
        issue(0, 32'h0, '0, 0, 0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("final_load_data", load_data, 32'hCAFEF00D);
        chk("queues_drained_end", 64'(res_q.size() + txn_q.size() + stall_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
